index_dispatcher: RTL
=====================

# index_dispatcher

Packs a serial stream of sparse (row, col) index entries into PE_NUMBER-lane batches. Each batch carries the count of entries still outstanding, so the downstream index parser can derive per-PE enables and mask the final partial batch. It sits between the index buffer read port and the index parser in the attention datapath. One batch is held at a time, behind a valid/ready handshake.

## Interface

Parameters:
- PE_NUMBER, 32: lanes per batch
- LOG2_HEIGHT, 4: row-index width per entry
- LOG2_PES, 4: col-index width per entry
- LOG2_K, 5: with LOG2_HEIGHT, sets count width W = LOG2_HEIGHT+LOG2_K

Ports:
- One clock, i_clk; asynchronous active-low reset, i_rst_n.
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_nnz_count  in  W  total entries for this job; sampled with i_start
- i_idx_valid  in  1  entry valid
- o_idx_ready  out  1  entry accepted when valid and ready are both high
- i_idx_row  in  LOG2_HEIGHT  entry row
- i_idx_col  in  LOG2_PES  entry col
- o_batch_valid  out  1  batch available
- i_batch_ready  in  1  downstream accepts batch
- o_row_index  out  PE_NUMBER*LOG2_HEIGHT  lane k at [k*LOG2_HEIGHT +: LOG2_HEIGHT]
- o_col_index  out  PE_NUMBER*LOG2_PES  lane k at [k*LOG2_PES +: LOG2_PES]
- o_remain_count  out  W  entries outstanding, including this batch
- o_busy  out  1  state is not IDLE
- o_done  out  1  one-cycle pulse at job end

## Operation

- State machine: IDLE, FILL, ISSUE, DONE.
- Internal registers:
  - rem (W bits): entries not yet issued.
  - fill (clog2(PE_NUMBER)+1 bits): lanes filled in the current batch.
  - target = min(rem, PE_NUMBER).
- IDLE:
  - i_start with i_nnz_count != 0: rem <= i_nnz_count, fill <= 0, lane registers <= 0, go to FILL.
  - i_start with i_nnz_count == 0: go to DONE; no batch is emitted.
- FILL:
  - o_idx_ready = 1.
  - Each accepted entry is written to lane `fill`, then fill increments.
  - When the accept makes fill == target, go to ISSUE.
  - Cycles with i_idx_valid low are idle; no accept.
- ISSUE:
  - o_batch_valid = 1 and o_remain_count = rem.
  - Lane outputs, o_remain_count and o_batch_valid stay stable until i_batch_ready.
  - Lanes >= target read zero.
  - On the handshake: rem <= rem - target, fill <= 0, lanes cleared.
  - Then go to DONE if rem - target == 0, otherwise to FILL.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- i_start outside IDLE is ignored.
- Entries are never accepted outside FILL, so excess upstream entries are never consumed.
- Arithmetic:
  - All counters are unsigned W bits; rem never underflows because target <= rem.
  - i_nnz_count = 2^W-1 must work.

## Timing

- Reset (async, i_rst_n low): state IDLE, o_idx_ready 0, o_batch_valid 0, o_row_index 0, o_col_index 0, o_remain_count 0, o_busy 0, o_done 0.
- Outputs are registered, except o_idx_ready and o_batch_valid, which decode state directly.
- i_start at cycle t: o_busy and o_idx_ready are high at t+1. For nnz = 0, o_done is high at t+1.
- Last entry of a batch accepted at cycle t: o_batch_valid high at t+1.
- Handshake at cycle t:
  - More entries pending: o_idx_ready high at t+1.
  - Final batch: o_done high at t+1, o_busy low at t+2.
- Throughput: one entry per cycle. A batch costs PE_NUMBER fill cycles plus at least one issue cycle; fill and issue do not overlap.
- Reset asserted mid-job: all state is discarded immediately. After release the block is in IDLE and needs a new i_start.

## Test plan

- nnz=70, continuous valid, batch_ready tied high -> three batches with o_remain_count 70, 38, 6. Third batch: lanes 0–5 hold entries 64–69, lanes 6–31 are zero. o_done fires one cycle after the third handshake.
- nnz=32 -> exactly one batch with o_remain_count 32 and all lanes filled; o_done follows; o_idx_ready never rises again.
- nnz=0 -> o_done at t+1 after start, o_batch_valid never asserted, no entries accepted.
- nnz=40 with i_batch_ready held low 5 cycles after first batch_valid -> outputs stable all 5 cycles, o_idx_ready low; second batch shows o_remain_count 8.
- Random i_idx_valid gaps, nnz=33 -> lane order equals acceptance order; i_start pulsed mid-job is ignored.
- i_rst_n low after 10 accepted entries of nnz=50 -> all outputs zero asynchronously; a fresh start with nnz=3 yields one batch with o_remain_count 3.

Source files
------------

// File: rtl/index_dispatcher.sv
// Packs a serial stream of sparse (row, col) index entries into PE_NUMBER-lane
// batches tagged with the count of entries still outstanding.
module index_dispatcher #(
  parameter int unsigned PE_NUMBER   = 32,
  parameter int unsigned LOG2_HEIGHT = 4,
  parameter int unsigned LOG2_PES    = 4,
  parameter int unsigned LOG2_K      = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [LOG2_HEIGHT+LOG2_K-1:0]   i_nnz_count,
  input  logic                            i_idx_valid,
  output logic                            o_idx_ready,
  input  logic [LOG2_HEIGHT-1:0]          i_idx_row,
  input  logic [LOG2_PES-1:0]             i_idx_col,
  output logic                            o_batch_valid,
  input  logic                            i_batch_ready,
  output logic [PE_NUMBER*LOG2_HEIGHT-1:0] o_row_index,
  output logic [PE_NUMBER*LOG2_PES-1:0]    o_col_index,
  output logic [LOG2_HEIGHT+LOG2_K-1:0]   o_remain_count,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned W  = LOG2_HEIGHT + LOG2_K;
  localparam int unsigned FW = $clog2(PE_NUMBER) + 1;
  localparam logic [W-1:0] PE_W = W'(PE_NUMBER);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   rem;
  logic [W-1:0]   target;
  logic [W-1:0]   rem_after;
  logic [FW-1:0]  fill;
  logic           accept;
  logic           fill_last;
  logic           issue_hs;
  logic           job_load;

  // Batch size is capped by what is left, so the last batch may be partial.
  always_comb begin
    target    = (rem < PE_W) ? rem : PE_W;
    rem_after = rem - target;
    accept    = i_idx_valid && (state == S_FILL);
    issue_hs  = i_batch_ready && (state == S_ISSUE);
    fill_last = accept && ((W'(fill) + W'(1)) == target);
    job_load  = (state == S_IDLE) && i_start && (i_nnz_count != '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_nnz_count != '0) ? S_FILL : S_DONE;
      S_FILL:  if (fill_last) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_hs) state_nxt = (rem_after == '0) ? S_DONE : S_FILL;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Handshake flags follow the state register directly.
  assign o_idx_ready    = (state == S_FILL);
  assign o_batch_valid  = (state == S_ISSUE);
  assign o_remain_count = rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem         <= '0;
      fill        <= '0;
      o_row_index <= '0;
      o_col_index <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_busy <= (state_nxt != S_IDLE);
      o_done <= (state_nxt == S_DONE);
      if (job_load) begin
        rem         <= i_nnz_count;
        fill        <= '0;
        o_row_index <= '0;
        o_col_index <= '0;
      end else if (accept) begin
        fill <= fill + FW'(1);
        for (int unsigned k = 0; k < PE_NUMBER; k++) begin
          if (fill == FW'(k)) begin
            o_row_index[k*LOG2_HEIGHT +: LOG2_HEIGHT] <= i_idx_row;
            o_col_index[k*LOG2_PES +: LOG2_PES]       <= i_idx_col;
          end
        end
      end else if (issue_hs) begin
        // Clearing lanes here keeps unused lanes of a partial batch at zero.
        rem         <= rem_after;
        fill        <= '0;
        o_row_index <= '0;
        o_col_index <= '0;
      end
    end
  end

endmodule
